fetch_instr_queue: RTL
======================

// Module: fetch_instr_queue
// PURPOSE
//  Decoupling queue between Instruction_Fetch and the decode stage.
//  Captures each {PC_IF, Instruction_Code} pair from fetch and presents it to decode in order.
//  Drives a stall back to fetch when full.
//  Flushes all entries on a taken branch/jump redirect.
// PARAMETERS
//  DEPTH      4             number of entries; power of 2, >= 2
//  ADDR_W     2             log2(DEPTH); read/write pointer width
//  NOP_INSTR  32'h00000013  instruction driven on out_instr while out_valid=0
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high reset
//  flush        in   1   redirect (PC_Src taken); discards queue contents
//  in_valid     in   1   fetch presents a valid instruction this cycle
//  in_pc        in   32  PC of incoming instruction (PC_IF)
//  in_instr     in   32  incoming instruction word (Instruction_Code)
//  in_ready     out  1   queue accepts a write this cycle (= !full)
//  fetch_stall  out  1   to fetch stall_flush; = full; PC must hold
//  out_valid    out  1   head entry valid (= !empty)
//  out_pc       out  32  PC of head entry; 0 when empty
//  out_instr    out  32  head instruction; NOP_INSTR when empty
//  out_ready    in   1   decode consumes head this cycle (low = decode stall)
//  count        out  ADDR_W+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x 64-bit array {pc, instr}, plus wr_ptr, rd_ptr (ADDR_W bits) and count (ADDR_W+1 bits).
//  - Pointers wrap modulo DEPTH (natural ADDR_W-bit overflow).
//  - push = in_valid & in_ready.
//  - pop = out_valid & out_ready.
//  - full = (count==DEPTH); empty = (count==0).
//  - in_ready, fetch_stall, out_valid and out_* are decoded from registered state only.
//    No combinational path from in_* to out_*, and none from out_ready to in_ready.
//  - Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. one cycle.
//    Empty-queue bypass is not permitted.
//  - Per-edge priority: reset > flush > push/pop.
//  - reset=1: wr_ptr=rd_ptr=0, count=0.
//    Outputs after the edge: out_valid=0, out_pc=0, out_instr=NOP_INSTR, in_ready=1, fetch_stall=0.
//    Array contents are don't-care.
//  - flush=1 (reset=0): same pointer/count clear as reset.
//    Any push and pop in that cycle are discarded; the redirect-target instruction is pushed on a later cycle.
//  - push only: write array[wr_ptr], wr_ptr+1, count+1.
//  - pop only: rd_ptr+1, count-1.
//  - push & pop same cycle: both pointers advance, count unchanged.
//    Legal at any count except full (in_ready=0) or empty (out_valid=0).
//  - Push while full: in_ready=0, so no push occurs; data is dropped and fetch must hold via fetch_stall.
//  - Pop while empty: no effect; count never underflows.
//  - When full with out_ready=1: the pop frees one slot; in_ready rises the next cycle.
//  - Order: strict FIFO; PCs leave in the same order they entered.
//  - Reset or flush mid-stream: takes effect at that edge regardless of in_valid/out_ready; no partial entry survives.
// TESTING
//  - Reset: assert reset 2 cycles with in_valid=1.
//    Expect count=0, out_valid=0, out_instr=32'h00000013, out_pc=0, in_ready=1.
//  - Fill: out_ready=0; push PC 0,4,8,C with instr A0..A3.
//    Expect count=4, fetch_stall=1, in_ready=0; a 5th push (PC 10) is not stored.
//  - Drain in order: from the full state set out_ready=1.
//    Expect out_pc 0,4,8,C on consecutive cycles, then out_valid=0 and count=0.
//  - Simultaneous push/pop at count=2, held 10 cycles: count stays 2.
//    Output PC sequence is continuous +4 with no duplicates or gaps; pointers wrap past DEPTH.
//  - Flush: count=3 with in_valid=1 and out_ready=1, assert flush one cycle.
//    Next cycle count=0, out_valid=0. Push PC 40 the following cycle; one cycle later out_pc=40.
//  - Latency: empty queue, push PC 20 at edge N; out_valid=0 before N and out_valid=1, out_pc=20 after N.

Source files
------------

// File: rtl/fetch_instr_queue.sv
// Decoupling FIFO between instruction fetch and decode: carries {pc, instr} pairs in order,
// stalls fetch when full, and empties on a redirect flush.
module fetch_instr_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    output logic              in_ready,
    output logic              fetch_stall,
    output logic              out_valid,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    entry_t            mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    entry_t            head;

    // Status and head presentation come only from registered state (no bypass).
    assign full        = (count == FULL_CNT);
    assign empty       = (count == '0);
    assign in_ready    = !full;
    assign fetch_stall = full;
    assign out_valid   = !empty;
    assign head        = mem[rd_ptr];
    assign out_pc      = empty ? 32'h0 : head.pc;
    assign out_instr   = empty ? NOP_INSTR : head.instr;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Pointer and occupancy update: reset > flush > push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; stale slots are never presented.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
        end
    end

endmodule
